// File: rtl/stream_fifo_if.sv
// stream_fifo_if: write-side and read-side valid/ready streams of stream_fifo
interface stream_fifo_if #(parameter int DataWidth = 16);
    logic [DataWidth-1:0] din_i;
    logic                 din_val_i;
    logic                 din_rdy_o;
    logic [DataWidth-1:0] dout_o;
    logic                 dout_val_o;
    logic                 dout_rdy_i;
    modport slave (input din_i, din_val_i, dout_rdy_i, output din_rdy_o, dout_o, dout_val_o);
    modport master (output din_i, din_val_i, dout_rdy_i, input din_rdy_o, dout_o, dout_val_o);
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: fall-through valid/ready FIFO with flush, level, watermarks and
// an optional peak-occupancy monitor enabled by STREAM_FIFO_PEAK_EN.
module stream_fifo #(
    parameter int DataWidth      = 16,
    parameter int Depth          = 8,
    parameter int AlmostFullThr  = Depth - 2,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   flush_i,
    stream_fifo_if.slave           bus,
    output logic [$clog2(Depth):0] level_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   almost_full_o,
    output logic                   almost_empty_o,
    output logic [$clog2(Depth):0] peak_level_o
);
    localparam int AW = $clog2(Depth);
    localparam int W = AW + 1;
    localparam logic [W-1:0] AfThr = W'(AlmostFullThr);
    localparam logic [W-1:0] AeThr = W'(AlmostEmptyThr);
    logic [DataWidth-1:0] mem_q [Depth];
    logic [W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic wr_en, rd_en;
    // Wrap bit differs with equal index bits only when the writer is a lap ahead
    assign full_o = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign almost_full_o = level_o >= AfThr;
    assign almost_empty_o = level_o <= AeThr;
    assign bus.din_rdy_o = !full_o && !flush_i && !arst_i;
    assign bus.dout_val_o = !empty_o && !flush_i;
    assign bus.dout_o = bus.dout_val_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign wr_en = bus.din_val_i && bus.din_rdy_o;
    assign rd_en = bus.dout_val_o && bus.dout_rdy_i;
    always_comb begin
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + W'(wr_en);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + W'(rd_en);
    end
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.din_i;
    end
`ifdef STREAM_FIFO_PEAK_EN
    logic [W-1:0] peak_q, peak_d, level_d;
    always_comb begin
        level_d = wr_ptr_d - rd_ptr_d;
        peak_d = flush_i ? '0 : (level_d > peak_q ? level_d : peak_q);
    end
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) peak_q <= '0;
        else peak_q <= peak_d;
    end
    assign peak_level_o = peak_q;
`else
    assign peak_level_o = '0;
`endif
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed and randomized-stall stimulus against a queue model of stream_fifo
module tb_stream_fifo;
    logic clk = 1'b0;
    logic arst = 1'b1;
    logic flush = 1'b0;
    logic [3:0] level, peak;
    logic full, empty, af, ae;
    logic [15:0] q[$];
    int vectors = 0;
    int miscompares = 0;
    int mpeak = 0;
    int pushes = 0;
    always #5 clk = ~clk;
    stream_fifo_if #(.DataWidth(16)) bus();
    stream_fifo #(.DataWidth(16), .Depth(8), .AlmostFullThr(6), .AlmostEmptyThr(2)) dut (
        .clk_i(clk), .arst_i(arst), .flush_i(flush), .bus(bus),
        .level_o(level), .full_o(full), .empty_o(empty),
        .almost_full_o(af), .almost_empty_o(ae), .peak_level_o(peak));
`ifdef STREAM_FIFO_PEAK_EN
    localparam bit PeakOn = 1'b1;
`else
    localparam bit PeakOn = 1'b0;
`endif
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        logic rdy, val;
        int n;
        #1;
        if (arst) begin
            q.delete();
            mpeak = 0;
        end
        n = q.size();
        rdy = !arst && !flush && n < 8;
        val = !flush && n > 0;
        chk("din_rdy", 32'(bus.din_rdy_o), 32'(rdy));
        chk("dout_val", 32'(bus.dout_val_o), 32'(val));
        chk("dout", 32'(bus.dout_o), val ? 32'(q[0]) : 32'h0);
        chk("level", 32'(level), 32'(n));
        chk("full", 32'(full), 32'(n == 8));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(af), 32'(n >= 6));
        chk("almost_empty", 32'(ae), 32'(n <= 2));
        chk("peak", 32'(peak), PeakOn ? 32'(mpeak) : 32'h0);
        if (flush || arst) q.delete();
        else begin
            if (val && bus.dout_rdy_i) void'(q.pop_front());
            if (rdy && bus.din_val_i) begin
                q.push_back(bus.din_i);
                pushes++;
            end
        end
        mpeak = (flush || arst) ? 0 : (q.size() > mpeak ? q.size() : mpeak);
        @(posedge clk);
        #1;
    endtask
    initial begin
        int p0;
        bit done;
        bus.din_i = '0;
        bus.din_val_i = 1'b0;
        bus.dout_rdy_i = 1'b0;
        tick();
        arst = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            bus.din_i = 16'(i);
            bus.din_val_i = 1'b1;
            tick();
        end
        bus.din_i = 16'h0009;
        tick();
        bus.din_val_i = 1'b0;
        chk("level_full", 32'(level), 32'd8);
        chk("peak_fill", 32'(peak), PeakOn ? 32'd8 : 32'd0);
        bus.dout_rdy_i = 1'b1;
        repeat (9) tick();
        bus.dout_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.din_i = 16'(16'h20 + i);
            bus.din_val_i = 1'b1;
            tick();
        end
        bus.dout_rdy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.din_i = 16'(16'h30 + i);
            tick();
        end
        chk("level_simul", 32'(level), 32'd4);
        bus.dout_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.din_i = 16'(16'h40 + i);
            tick();
        end
        bus.din_i = 16'h00ff;
        bus.dout_rdy_i = 1'b1;
        tick();
        chk("level_full_read", 32'(level), 32'd7);
        bus.din_val_i = 1'b0;
        repeat (8) tick();
        p0 = pushes;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            bus.din_i = 16'(16'h100 + pushes - p0);
            bus.din_val_i = (pushes - p0 < 40) && ($urandom_range(0, 3) != 0);
            bus.dout_rdy_i = $urandom_range(0, 2) != 0;
            tick();
            done = (pushes - p0 >= 40) && (q.size() == 0);
        end
        chk("stream_done", 32'(done), 32'd1);
        bus.din_val_i = 1'b0;
        bus.dout_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.din_i = 16'(16'h50 + i);
            bus.din_val_i = 1'b1;
            tick();
        end
        bus.din_i = 16'hdead;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.din_val_i = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_peak", 32'(peak), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.din_i = 16'(16'h60 + i);
            bus.din_val_i = 1'b1;
            tick();
        end
        bus.din_i = 16'h0055;
        arst = 1'b1;
        tick();
        arst = 1'b0;
        bus.din_val_i = 1'b0;
        tick();
        bus.din_i = 16'hbeef;
        bus.din_val_i = 1'b1;
        tick();
        bus.din_val_i = 1'b0;
        bus.dout_rdy_i = 1'b1;
        #1;
        chk("beef", 32'(bus.dout_o), 32'h0000beef);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous valid/ready FIFO, successor to the basic fall-through FIFO. Adds correct simultaneous read/write, a synchronous flush, an occupancy count, full/empty flags, programmable almost-full/almost-empty watermarks and an optional peak-occupancy monitor. Sits between streaming producer/consumer stages for rate decoupling and backpressure.

## Interface
- DataWidth, 16, payload width in bits (≥1)
- Depth, 8, number of entries; power of two, ≥2
- AlmostFullThr, Depth-2, almost_full_o asserts when level ≥ this value (1..Depth)
- AlmostEmptyThr, 2, almost_empty_o asserts when level ≤ this value (0..Depth-1)
- clk_i  in  1  sole clock, rising edge
- arst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous clear of contents
- din_i  in  DataWidth  write data
- din_val_i  in  1  write valid
- din_rdy_o  out  1  write ready
- dout_o  out  DataWidth  read data (head entry)
- dout_val_o  out  1  read valid
- dout_rdy_i  in  1  read ready
- level_o  out  $clog2(Depth)+1  current occupancy, 0..Depth
- full_o / empty_o  out  1 each  level==Depth / level==0
- almost_full_o / almost_empty_o  out  1 each  watermark flags
- peak_level_o  out  $clog2(Depth)+1  highest level since reset/flush

## Operation
- Pointers wr_ptr/rd_ptr are $clog2(Depth)+1 bits; MSB is the wrap bit. Full = MSBs differ, low bits equal; empty = pointers equal. Increment wraps naturally modulo 2·Depth.
- din_rdy_o = !full && !flush_i; dout_val_o = !empty && !flush_i.
- Write handshake = din_val_i && din_rdy_o: store din_i at wr_ptr, wr_ptr+1.
- Read handshake = dout_val_o && dout_rdy_i: rd_ptr+1.
- Both handshakes in one cycle: both execute independently; level unchanged. No ready-through: when full, din_rdy_o stays 0 even if a read occurs that cycle.
- dout_o = mem[rd_ptr] when dout_val_o=1, else 0 (forced zero, fall-through, combinational).
- level_o = wr_ptr − rd_ptr (modulo 2·Depth). Flags are combinational from pointers.
- flush_i: at next edge wr_ptr, rd_ptr ← 0; no handshake completes in a flush cycle (ready/valid forced low). Memory contents are not cleared.
- arst_i: pointers and peak register ← 0 immediately; memory is not reset.

## Timing
- Write-to-read latency: data written at edge N appears on dout_o with dout_val_o=1 in cycle after N (one cycle).
- Read handshake at edge N: next entry (or dout_val_o=0) visible immediately after N.
- Flag/level updates visible the cycle after the causing edge.
- Reset values (while and after arst_i): din_rdy_o 1 (0 while arst_i asserted), dout_val_o 0, dout_o 0, level_o 0, full_o 0, empty_o 1, almost_full_o 0, almost_empty_o 1, peak_level_o 0.
- Reset mid-operation: all in-flight data lost; no handshake at the edge coincident with arst_i.

## Configuration
- STREAM_FIFO_PEAK_EN defined: peak register updates each edge to max(peak, next level); cleared by arst_i and flush_i (flush has priority).
- Undefined: no peak register; peak_level_o tied to 0.

## Test plan
- Fill: 8 writes 0x0001..0x0008, dout_rdy_i=0 → level 8, full_o=1, din_rdy_o=0, almost_full_o set from level 6, din_val_i held on a 9th word is not accepted.
- Drain: from full, dout_rdy_i=1 for 8 cycles → dout_o 0x0001..0x0008 in order, then dout_val_o=0, dout_o=0, empty_o=1, almost_empty_o set at level 2.
- Simultaneous: at level 4 hold din_val_i=dout_rdy_i=1 for 10 cycles → level stays 4, output order equals input order; at full with dout_rdy_i=1, one read, no write that cycle.
- Wrap-around: stream 40 incrementing words with random stalls on both sides → no loss/duplication, pointers wrap ≥4 times, full/empty correct at each wrap.
- Flush: at level 5 assert flush_i with din_val_i=1 → next cycle level 0, empty_o=1, no word accepted; peak_level_o=0 (macro on) or 0 (macro off).
- Reset: assert arst_i mid-stream at level 3 between edges → outputs take reset values immediately; after release, first write 0xBEEF read back one cycle later; with macro on, peak after the fill test reads 8.
